// File: rtl/alu_operand_stage.sv
// Operand-select stage between decode and the ALU.
// It forwards source registers from the EX and WB stages, decodes
// ALUOp, and keeps the result in a single ready/valid holding register.
module alu_operand_stage #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RA_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic            funct7b5,
    input  logic [RA_W-1:0] rs1_addr,
    input  logic [RA_W-1:0] rs2_addr,
    input  logic [RA_W-1:0] rd_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic            ex_fwd_en,
    input  logic            wb_fwd_en,
    input  logic [RA_W-1:0] ex_fwd_rd,
    input  logic [RA_W-1:0] wb_fwd_rd,
    input  logic [XLEN-1:0] ex_fwd_data,
    input  logic [XLEN-1:0] wb_fwd_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] A,
    output logic [XLEN-1:0] B,
    output logic [3:0]      ALUOp,
    output logic [RA_W-1:0] out_rd,
    output logic            out_wen,
    output logic            illegal
);

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0101;

    logic            valid_q, valid_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d;
    logic [3:0]      op_q, op_d;
    logic [RA_W-1:0] rd_q;
    logic            wen_q, wen_d, ill_q, ill_d;
    logic [XLEN-1:0] rs1_fwd, rs2_fwd;
    logic            capture;

    // Resolve one source: x0 reads zero, the younger EX result beats WB
    function automatic logic [XLEN-1:0] fwd_operand(
        input logic [RA_W-1:0] addr,
        input logic [XLEN-1:0] rf_data
    );
        logic [XLEN-1:0] res;
        res = rf_data;
        if (addr == '0) begin
            res = '0;
        end else if (ex_fwd_en && (ex_fwd_rd == addr)) begin
            res = ex_fwd_data;
        end else if (wb_fwd_en && (wb_fwd_rd == addr)) begin
            res = wb_fwd_data;
        end
        return res;
    endfunction

    assign rs1_fwd  = fwd_operand(rs1_addr, rs1_data);
    assign rs2_fwd  = fwd_operand(rs2_addr, rs2_data);
    assign in_ready = !valid_q || out_ready;
    assign capture  = in_valid && in_ready;

    // Decode the incoming instruction into operands, ALUOp and flags
    always_comb begin
        a_d   = '0;
        b_d   = '0;
        op_d  = ALU_ADD;
        wen_d = 1'b0;
        ill_d = 1'b1;
        if ((opcode == OPC_R) || (opcode == OPC_I)) begin
            ill_d = 1'b0;
            unique case (funct3)
                3'b000:  op_d = (opcode == OPC_R && funct7b5) ? ALU_SUB : ALU_ADD;
                3'b111:  op_d = ALU_AND;
                3'b110:  op_d = ALU_OR;
                3'b100:  op_d = ALU_XOR;
                3'b010:  op_d = ALU_SLT;
                default: ill_d = 1'b1;
            endcase
        end
        if (!ill_d) begin
            a_d   = rs1_fwd;
            b_d   = (opcode == OPC_R) ? rs2_fwd : imm;
            wen_d = (rd_addr != '0);
        end else begin
            op_d = ALU_ADD;
        end
    end

    // Holding-register occupancy: flush wins, then capture, then drain
    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (capture) begin
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Valid flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Payload register, loaded only on an accepted handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= ALU_ADD;
            rd_q  <= '0;
            wen_q <= 1'b0;
            ill_q <= 1'b0;
        end else if (capture) begin
            a_q   <= a_d;
            b_q   <= b_d;
            op_q  <= op_d;
            rd_q  <= rd_addr;
            wen_q <= wen_d;
            ill_q <= ill_d;
        end
    end

    assign out_valid = valid_q;
    assign A         = a_q;
    assign B         = b_q;
    assign ALUOp     = op_q;
    assign out_rd    = rd_q;
    assign out_wen   = wen_q;
    assign illegal   = ill_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: directed scenarios plus random traffic.
module tb_alu_operand_stage;

    logic        clk, rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, flush;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr, ex_fwd_rd, wb_fwd_rd, out_rd;
    logic [31:0] rs1_data, rs2_data, imm, ex_fwd_data, wb_fwd_data, A, B;
    logic        ex_fwd_en, wb_fwd_en, out_wen, illegal;
    logic [3:0]  ALUOp;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        wen;
        logic        ill;
    } exp_t;

    exp_t sb_q[$];
    bit   model_valid;
    int   n_checks, n_errors;

    alu_operand_stage #(.XLEN(32), .RA_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .ex_fwd_en(ex_fwd_en), .wb_fwd_en(wb_fwd_en),
        .ex_fwd_rd(ex_fwd_rd), .wb_fwd_rd(wb_fwd_rd),
        .ex_fwd_data(ex_fwd_data), .wb_fwd_data(wb_fwd_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .A(A), .B(B), .ALUOp(ALUOp), .out_rd(out_rd), .out_wen(out_wen),
        .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Value a source register should read, given the bypass network state
    function automatic logic [31:0] src_value(input logic [4:0] r, input logic [31:0] rf);
        if (r == 5'd0) return 32'd0;
        if (ex_fwd_en && ex_fwd_rd == r) return ex_fwd_data;
        if (wb_fwd_en && wb_fwd_rd == r) return wb_fwd_data;
        return rf;
    endfunction

    // Reference result for the instruction currently on the inputs
    function automatic exp_t ref_model();
        exp_t e;
        int   code;
        bit   is_r, is_i;
        is_r = (opcode == 7'h33);
        is_i = (opcode == 7'h13);
        case (funct3)
            3'd0:    code = (is_r && funct7b5) ? 1 : 0;
            3'd7:    code = 2;
            3'd6:    code = 3;
            3'd4:    code = 4;
            3'd2:    code = 5;
            default: code = -1;
        endcase
        if (!(is_r || is_i) || code < 0) begin
            e = '{a: 32'd0, b: 32'd0, op: 4'd0, rd: rd_addr, wen: 1'b0, ill: 1'b1};
        end else begin
            e.a   = src_value(rs1_addr, rs1_data);
            e.b   = is_r ? src_value(rs2_addr, rs2_data) : imm;
            e.op  = 4'(code);
            e.rd  = rd_addr;
            e.wen = (rd_addr != 5'd0);
            e.ill = 1'b0;
        end
        return e;
    endfunction

    // One clock of stimulus: inputs already driven, updates the scoreboard at the edge
    task automatic step();
        bit   exp_rdy, cap;
        exp_t e;
        #1;
        exp_rdy = !model_valid || out_ready;
        check("in_ready", 128'(in_ready), 128'(exp_rdy));
        cap = in_valid && exp_rdy;
        e = ref_model();
        @(posedge clk);
        if (flush) begin
            if (model_valid && !out_ready) void'(sb_q.pop_front());
            model_valid = 0;
        end else if (cap) begin
            sb_q.push_back(e);
            model_valid = 1;
        end else if (out_ready) begin
            model_valid = 0;
        end
        #1;
    endtask

    task automatic set_idle();
        in_valid = 0; out_ready = 1; flush = 0; ex_fwd_en = 0; wb_fwd_en = 0;
        ex_fwd_rd = 0; wb_fwd_rd = 0; ex_fwd_data = 0; wb_fwd_data = 0;
    endtask

    task automatic set_instr(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                             input logic [4:0] r1, input logic [31:0] d1,
                             input logic [4:0] r2, input logic [31:0] d2,
                             input logic [4:0] rd, input logic [31:0] im);
        opcode = opc; funct3 = f3; funct7b5 = f7; rs1_addr = r1; rs1_data = d1;
        rs2_addr = r2; rs2_data = d2; rd_addr = rd; imm = im;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_out_valid"}, 128'(out_valid), 128'(0));
        check({tag, "_A"}, 128'(A), 128'(0));
        check({tag, "_B"}, 128'(B), 128'(0));
        check({tag, "_ALUOp"}, 128'(ALUOp), 128'(0));
        check({tag, "_out_rd"}, 128'(out_rd), 128'(0));
        check({tag, "_out_wen"}, 128'(out_wen), 128'(0));
        check({tag, "_illegal"}, 128'(illegal), 128'(0));
    endtask

    // Monitor: occupancy must match the scoreboard; consumed entries are compared
    always @(negedge clk) begin
        if (rst_n) begin
            check("occupancy", 128'(out_valid), 128'(sb_q.size() != 0));
            if (out_valid && out_ready && sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check("payload", 128'({A, B, ALUOp, out_rd, out_wen, illegal}), 128'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [74:0] held;
        rst_n = 0;
        set_idle();
        set_instr(7'h33, 3'd0, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);
        #3;
        check_zero_outputs("reset");
        check("reset_in_ready", 128'(in_ready), 128'(1));
        #9 rst_n = 1;
        @(posedge clk); #1;

        // ADD x3 = x1 + x2
        set_instr(7'h33, 3'd0, 1'b0, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 32'd0);
        in_valid = 1;
        step();
        check("add_A", 128'(A), 128'(5));
        check("add_B", 128'(B), 128'(7));
        check("add_op", 128'(ALUOp), 128'(0));
        check("add_wen", 128'(out_wen), 128'(1));
        check("add_rd", 128'(out_rd), 128'(3));

        // Forwarding priority
        set_instr(7'h33, 3'd0, 1'b0, 5'd4, 32'h11, 5'd2, 32'd7, 5'd3, 32'd0);
        ex_fwd_en = 1; ex_fwd_rd = 5'd4; ex_fwd_data = 32'hAA;
        wb_fwd_en = 1; wb_fwd_rd = 5'd4; wb_fwd_data = 32'hBB;
        step();
        check("fwd_ex", 128'(A), 128'(32'hAA));
        ex_fwd_en = 0;
        step();
        check("fwd_wb", 128'(A), 128'(32'hBB));
        rs1_addr = 5'd0;
        step();
        check("fwd_x0", 128'(A), 128'(0));
        set_idle();

        // Backpressure
        set_instr(7'h33, 3'd0, 1'b0, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 32'd0);
        in_valid = 1;
        step();
        held = {A, B, ALUOp, out_rd, out_wen, illegal};
        set_instr(7'h33, 3'd4, 1'b0, 5'd1, 32'h1234, 5'd2, 32'h0F0F, 5'd9, 32'd0);
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_in_ready", 128'(in_ready), 128'(0));
            check("bp_hold", 128'({A, B, ALUOp, out_rd, out_wen, illegal}), 128'(held));
        end
        out_ready = 1;
        step();
        check("bp_release_A", 128'(A), 128'(32'h1234));
        check("bp_release_op", 128'(ALUOp), 128'(4));

        // ADDI with rd=0 and an all-ones immediate, then a branch opcode
        set_instr(7'h13, 3'd0, 1'b1, 5'd1, 32'd5, 5'd2, 32'd7, 5'd0, 32'hFFFFFFFF);
        step();
        check("addi_op", 128'(ALUOp), 128'(0));
        check("addi_B", 128'(B), 128'(32'hFFFFFFFF));
        check("addi_wen", 128'(out_wen), 128'(0));
        opcode = 7'b1100011;
        step();
        check("branch_illegal", 128'(illegal), 128'(1));
        check("branch_wen", 128'(out_wen), 128'(0));
        check("branch_A", 128'(A), 128'(0));

        // Flush while holding and capturing at the same time
        set_instr(7'h33, 3'd7, 1'b0, 5'd1, 32'd3, 5'd2, 32'd6, 5'd5, 32'd0);
        flush = 1;
        step();
        check("flush_valid", 128'(out_valid), 128'(0));
        flush = 0;

        // Reset pulse in the middle of a stall
        step();
        out_ready = 0;
        step();
        step();
        rst_n = 0;
        #1;
        check_zero_outputs("midrst");
        sb_q.delete();
        model_valid = 0;
        in_valid = 0;
        @(posedge clk);
        @(negedge clk);
        set_instr(7'h33, 3'd0, 1'b1, 5'd1, 32'd9, 5'd2, 32'd4, 5'd7, 32'd0);
        in_valid = 1; out_ready = 1;
        rst_n = 1;
        step();
        check("post_rst_capture", 128'(out_valid), 128'(1));
        check("post_rst_sub", 128'(ALUOp), 128'(1));

        // Random traffic
        for (int n = 0; n < 500; n++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            opcode   = (sel < 4) ? 7'h33 : (sel < 8) ? 7'h13 : 7'($urandom);
            funct3   = 3'($urandom);
            funct7b5 = 1'($urandom);
            rs1_addr = 5'($urandom_range(0, 7));
            rs2_addr = 5'($urandom_range(0, 7));
            rd_addr  = 5'($urandom_range(0, 7));
            rs1_data = $urandom; rs2_data = $urandom; imm = $urandom;
            ex_fwd_en = 1'($urandom); ex_fwd_rd = 5'($urandom_range(0, 7)); ex_fwd_data = $urandom;
            wb_fwd_en = 1'($urandom); wb_fwd_rd = 5'($urandom_range(0, 7)); wb_fwd_data = $urandom;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            step();
        end

        set_idle();
        for (int i = 0; i < 4; i++) step();
        check("drain_empty", 128'(sb_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
